iss_wide: RTL

Parametrised in-order issue stage between the instruction queue (IQ) and the execution units. It scans a WIDTH-entry window at the IQ head and issues a strictly in-order prefix to a branch unit, a load/store port, a mul/div port and N_ALU ALU ports. Every unit port is a registered valid/ready output. A taken branch is resolved one cycle after issue and truncates wrong-path issue after its delay slot.

---
 rtl/iss_wide_if.sv | 112 +++++++++++
 rtl/iss_wide.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/iss_wide_if.sv
// Shared issue-stage types plus the IQ/unit-port bundle between iss_wide and its neighbours.
// Branch GT/GE/LT/LE compare operands as signed 32-bit values; rob_slot is carried at max width.
package iss_wide_pkg;
  localparam int ROB_SLOT_MAX = 8;

  typedef enum logic [2:0] {
    BR_EQ     = 3'd0,
    BR_NE     = 3'd1,
    BR_GT     = 3'd2,
    BR_GE     = 3'd3,
    BR_LT     = 3'd4,
    BR_LE     = 3'd5,
    BR_UNCOND = 3'd6
  } br_cond_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] branch_target;
    logic        is_branch;
    logic        is_jmp;
    logic        is_ls;
    logic        is_muldiv;
    br_cond_t    cond;
    logic        rformat;
    logic        A_reg_valid;
    logic        B_reg_valid;
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
  } dec_inst_t;

  typedef struct packed {
    dec_inst_t                 dec_inst;
    logic [ROB_SLOT_MAX-1:0]   rob_slot;
  } iq_entry_t;

  typedef struct packed {
    logic [31:0] result_lo;
    logic [4:0]  dest_reg;
    logic        dest_reg_valid;
    logic        pc_valid;
  } rob_entry_t;
endpackage

interface iss_wide_if #(
  parameter int WIDTH         = 4,
  parameter int N_ALU         = 2,
  parameter int ROB_DEPTHLOG2 = 4,
  parameter int CNT_W         = 32
);
  import iss_wide_pkg::*;
  localparam int IW = $clog2(WIDTH);

  logic [WIDTH-1:0]                        ext_valid;
  iq_entry_t [WIDTH-1:0]                   insns;
  logic [WIDTH-1:0][31:0]                  op_a;
  logic [WIDTH-1:0][31:0]                  op_b;
  logic [WIDTH-1:0]                        op_a_rdy;
  logic [WIDTH-1:0]                        op_b_rdy;
  logic                                    ext_enable;
  logic [IW-1:0]                           ext_consumed;
  logic                                    flush;
  logic                                    branch_stall;

  logic                                    ls_valid;
  logic                                    ls_ready;
  logic [31:0]                             ls_A;
  logic [31:0]                             ls_B;
  dec_inst_t                               ls_inst;
  logic [ROB_DEPTHLOG2-1:0]                ls_rob_slot;

  logic                                    mul_valid;
  logic                                    mul_ready;
  logic [31:0]                             mul_A;
  logic [31:0]                             mul_B;
  dec_inst_t                               mul_inst;
  logic [ROB_DEPTHLOG2-1:0]                mul_rob_slot;

  logic [N_ALU-1:0]                        alu_valid;
  logic [N_ALU-1:0]                        alu_ready;
  logic [N_ALU-1:0][31:0]                  alu_A;
  logic [N_ALU-1:0][31:0]                  alu_B;
  dec_inst_t [N_ALU-1:0]                   alu_inst;
  logic [N_ALU-1:0][ROB_DEPTHLOG2-1:0]     alu_rob_slot;

  logic [31:0]                             new_pc;
  logic                                    new_pc_valid;
  logic                                    wr_valid;
  logic [ROB_DEPTHLOG2-1:0]                wr_slot;
  rob_entry_t                              wr_data;
  logic [CNT_W-1:0]                        stat_issued;
  logic [CNT_W-1:0]                        stat_stall;

  modport master (
    input  ext_valid, insns, op_a, op_b, op_a_rdy, op_b_rdy, flush, branch_stall,
    input  ls_ready, mul_ready, alu_ready,
    output ext_enable, ext_consumed,
    output ls_valid, ls_A, ls_B, ls_inst, ls_rob_slot,
    output mul_valid, mul_A, mul_B, mul_inst, mul_rob_slot,
    output alu_valid, alu_A, alu_B, alu_inst, alu_rob_slot,
    output new_pc, new_pc_valid, wr_valid, wr_slot, wr_data, stat_issued, stat_stall
  );

  modport slave (
    output ext_valid, insns, op_a, op_b, op_a_rdy, op_b_rdy, flush, branch_stall,
    output ls_ready, mul_ready, alu_ready,
    input  ext_enable, ext_consumed,
    input  ls_valid, ls_A, ls_B, ls_inst, ls_rob_slot,
    input  mul_valid, mul_A, mul_B, mul_inst, mul_rob_slot,
    input  alu_valid, alu_A, alu_B, alu_inst, alu_rob_slot,
    input  new_pc, new_pc_valid, wr_valid, wr_slot, wr_data, stat_issued, stat_stall
  );
endinterface

// File: rtl/iss_wide.sv
// iss_wide: in-order prefix issue from a WIDTH-entry IQ window to branch/ls/mul/alu ports, 1-cycle latency.
// A port reloads only when ~valid|ready (holds data while stalled); ISS_STATS_EN builds the statistics counters.
module iss_wide
  import iss_wide_pkg::*;
#(
  parameter int WIDTH         = 4,
  parameter int N_ALU         = 2,
  parameter int ROB_DEPTHLOG2 = 4,
  parameter int CNT_W         = 32
) (
  input logic         clock,
  input logic         reset_n,
  iss_wide_if.master  bus
);
  localparam int IW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  logic                   ls_free;
  logic                   mul_free;
  logic [N_ALU-1:0]       alu_free;
  logic [WIDTH-1:0]       opnd_ok;
  logic [WIDTH:0]         valid_ext;

  assign ls_free   = ~bus.ls_valid | bus.ls_ready;
  assign mul_free  = ~bus.mul_valid | bus.mul_ready;
  assign alu_free  = ~bus.alu_valid | bus.alu_ready;
  assign valid_ext = {1'b0, bus.ext_valid};

  always_comb begin
    opnd_ok = '0;
    for (int i = 0; i < WIDTH; i++) begin
      opnd_ok[i] = (bus.op_a_rdy[i] | ~bus.insns[i].dec_inst.A_reg_valid) &
                   (bus.op_b_rdy[i] | ~bus.insns[i].dec_inst.B_reg_valid);
    end
  end

  logic [CW-1:0]             cnt;
  logic                      br_take, ls_take, mul_take;
  logic [N_ALU-1:0]          alu_take;
  logic [IW-1:0]             br_sel, ls_sel, mul_sel;
  logic [N_ALU-1:0][IW-1:0]  alu_sel;
  logic                      scan_done, slot_next, routed, alu_hit;
  dec_inst_t                 d;

  // Scan the window in order; a routed branch arms slot_next so the entry after it ends the scan.
  always_comb begin
    cnt       = '0;
    br_take   = 1'b0;
    ls_take   = 1'b0;
    mul_take  = 1'b0;
    alu_take  = '0;
    br_sel    = '0;
    ls_sel    = '0;
    mul_sel   = '0;
    alu_sel   = '0;
    scan_done = bus.flush;
    slot_next = 1'b0;
    routed    = 1'b0;
    alu_hit   = 1'b0;
    d         = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (!scan_done) begin
        d      = bus.insns[i].dec_inst;
        routed = 1'b0;
        if (valid_ext[i] && opnd_ok[i]) begin
          if (d.is_branch || d.is_jmp) begin
            if (!bus.branch_stall && !br_take && valid_ext[i+1]) begin
              br_take = 1'b1;
              br_sel  = IW'(i);
              routed  = 1'b1;
            end
          end else if (d.is_ls) begin
            if (ls_free && !ls_take) begin
              ls_take = 1'b1;
              ls_sel  = IW'(i);
              routed  = 1'b1;
            end
          end else if (d.is_muldiv) begin
            if (mul_free && !mul_take) begin
              mul_take = 1'b1;
              mul_sel  = IW'(i);
              routed   = 1'b1;
            end
          end else begin
            alu_hit = 1'b0;
            for (int k = 0; k < N_ALU; k++) begin
              if (!alu_hit && alu_free[k] && !alu_take[k]) begin
                alu_take[k] = 1'b1;
                alu_sel[k]  = IW'(i);
                alu_hit     = 1'b1;
              end
            end
            if (!alu_hit && mul_free && !mul_take) begin
              mul_take = 1'b1;
              mul_sel  = IW'(i);
              alu_hit  = 1'b1;
            end
            routed = alu_hit;
          end
        end
        if (routed) cnt = cnt + CW'(1);
        scan_done = !routed || slot_next;
        slot_next = routed && (d.is_branch || d.is_jmp);
      end
    end
  end

  assign bus.ext_enable   = (cnt != '0);
  assign bus.ext_consumed = (cnt == '0) ? '0 : IW'(cnt - CW'(1));

  dec_inst_t   bd;
  logic [31:0] ba, bb, br_target;
  logic        cond_true, br_taken;
  rob_entry_t  link_dat;

  always_comb begin
    bd = bus.insns[br_sel].dec_inst;
    ba = bus.op_a[br_sel];
    bb = bus.op_b[br_sel];
    case (bd.cond)
      BR_EQ:     cond_true = (ba == bb);
      BR_NE:     cond_true = (ba != bb);
      BR_GT:     cond_true = ($signed(ba) >  $signed(bb));
      BR_GE:     cond_true = ($signed(ba) >= $signed(bb));
      BR_LT:     cond_true = ($signed(ba) <  $signed(bb));
      BR_LE:     cond_true = ($signed(ba) <= $signed(bb));
      BR_UNCOND: cond_true = 1'b1;
      default:   cond_true = 1'b0;
    endcase
    br_taken                = bd.is_jmp | cond_true;
    br_target               = bd.rformat ? ba : bd.branch_target;
    link_dat.result_lo      = bd.pc + 32'd8;
    link_dat.dest_reg       = bd.dest_reg;
    link_dat.dest_reg_valid = bd.dest_reg_valid;
    link_dat.pc_valid       = br_taken;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bus.ls_valid     <= 1'b0;
      bus.ls_A         <= '0;
      bus.ls_B         <= '0;
      bus.ls_inst      <= '0;
      bus.ls_rob_slot  <= '0;
      bus.mul_valid    <= 1'b0;
      bus.mul_A        <= '0;
      bus.mul_B        <= '0;
      bus.mul_inst     <= '0;
      bus.mul_rob_slot <= '0;
      bus.alu_valid    <= '0;
      bus.alu_A        <= '0;
      bus.alu_B        <= '0;
      bus.alu_inst     <= '0;
      bus.alu_rob_slot <= '0;
      bus.new_pc       <= '0;
      bus.new_pc_valid <= 1'b0;
      bus.wr_valid     <= 1'b0;
      bus.wr_slot      <= '0;
      bus.wr_data      <= '0;
    end else begin
      if (bus.flush) begin
        bus.ls_valid <= 1'b0;
      end else if (ls_take) begin
        bus.ls_valid    <= 1'b1;
        bus.ls_A        <= bus.op_a[ls_sel];
        bus.ls_B        <= bus.op_b[ls_sel];
        bus.ls_inst     <= bus.insns[ls_sel].dec_inst;
        bus.ls_rob_slot <= bus.insns[ls_sel].rob_slot[ROB_DEPTHLOG2-1:0];
      end else if (bus.ls_ready) begin
        bus.ls_valid <= 1'b0;
      end

      if (bus.flush) begin
        bus.mul_valid <= 1'b0;
      end else if (mul_take) begin
        bus.mul_valid    <= 1'b1;
        bus.mul_A        <= bus.op_a[mul_sel];
        bus.mul_B        <= bus.op_b[mul_sel];
        bus.mul_inst     <= bus.insns[mul_sel].dec_inst;
        bus.mul_rob_slot <= bus.insns[mul_sel].rob_slot[ROB_DEPTHLOG2-1:0];
      end else if (bus.mul_ready) begin
        bus.mul_valid <= 1'b0;
      end

      for (int k = 0; k < N_ALU; k++) begin
        if (bus.flush) begin
          bus.alu_valid[k] <= 1'b0;
        end else if (alu_take[k]) begin
          bus.alu_valid[k]    <= 1'b1;
          bus.alu_A[k]        <= bus.op_a[alu_sel[k]];
          bus.alu_B[k]        <= bus.op_b[alu_sel[k]];
          bus.alu_inst[k]     <= bus.insns[alu_sel[k]].dec_inst;
          bus.alu_rob_slot[k] <= bus.insns[alu_sel[k]].rob_slot[ROB_DEPTHLOG2-1:0];
        end else if (bus.alu_ready[k]) begin
          bus.alu_valid[k] <= 1'b0;
        end
      end

      // br_take is already suppressed under flush, so both pulses clear with it.
      bus.new_pc_valid <= br_take & br_taken;
      bus.wr_valid     <= br_take;
      if (br_take) begin
        bus.new_pc  <= br_target;
        bus.wr_slot <= bus.insns[br_sel].rob_slot[ROB_DEPTHLOG2-1:0];
        bus.wr_data <= link_dat;
      end
    end
  end

`ifdef ISS_STATS_EN
  logic [CNT_W-1:0] issued_q, stall_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      issued_q <= '0;
      stall_q  <= '0;
    end else begin
      issued_q <= issued_q + CNT_W'(cnt);
      if (bus.ext_valid[0] && !bus.ext_enable) stall_q <= stall_q + CNT_W'(1);
    end
  end

  assign bus.stat_issued = issued_q;
  assign bus.stat_stall  = stall_q;
`else
  assign bus.stat_issued = '0;
  assign bus.stat_stall  = '0;
`endif
endmodule
